alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, handshaked successor to the single-cycle 4-bit ALU.
- Operands are WIDTH bits wide. Results are 2*WIDTH bits wide.
- Add, subtract, reverse-subtract, AND and OR complete in one cycle.
- Multiply and divide are iterative (shift-add and restoring), taking WIDTH cycles each. This keeps area small.
- Valid/ready on both sides, plus carry, zero and divide-by-zero flags. Sits between the pin-level input unpacker and the output mux.

Parameters:
WIDTH, 4, operand width in bits (legal range 2..16).

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active low.
in_valid  input  1  operands and op are valid this cycle.
in_ready  output  1  block can accept an operation.
op  input  3  000 a+b, 001 a-b, 010 b-a, 011 a*b, 100 a/b, 101 b/a, 110 a&b, 111 a|b.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
result  output  2*WIDTH  see arithmetic rules.
carry  output  1  add carry-out, or borrow for subtract ops; 0 for all other ops.
zero  output  1  result == 0 over the full 2*WIDTH bits.
div_zero  output  1  divisor was 0 on a divide op.

Behaviour:
- Reset, sampled on clk while rst_n=0: state IDLE; out_valid=0; result=0; carry=0; zero=0; div_zero=0; internal counter and shift registers cleared. Reset wins over any other event in the same cycle, including mid-BUSY; the in-flight operation is discarded.
- State machine: IDLE, BUSY, DONE.
  - in_ready = 1 only in IDLE. Accept = in_valid & in_ready. Operands and op are latched on accept.
  - IDLE, accept of op 000/001/010/110/111 -> DONE next cycle (latency 1).
  - IDLE, accept of divide with zero divisor -> DONE next cycle (latency 1).
  - IDLE, accept of 011, or 100/101 with non-zero divisor -> BUSY. Counter loads WIDTH-1.
  - BUSY: one shift-add or restoring-subtract step per cycle. At counter == 0 -> DONE. Accept-to-out_valid latency is WIDTH+1 cycles.
  - DONE: out_valid=1. result and flags are held stable while out_ready=0. out_ready=1 -> IDLE next cycle, with out_valid=0.
  - No back-to-back accept in the DONE cycle; minimum issue interval is 2 cycles.
- in_valid is ignored outside IDLE. op, a and b may change freely after accept.
- Arithmetic rules (all unsigned):
  - Add: result[WIDTH-1:0] = a+b mod 2^WIDTH; carry = bit WIDTH of the sum; upper half 0.
  - Sub (001/010): low half = difference mod 2^WIDTH; carry = 1 when minuend < subtrahend; upper half 0.
  - Mul: full 2*WIDTH-bit product; carry 0.
  - Div (100 a/b, 101 b/a): result = {remainder, quotient}, each WIDTH bits.
  - Divide by zero: quotient all ones, remainder = dividend, div_zero=1. div_zero is 0 for every other case.
  - AND/OR: low half = bitwise result; upper half 0.
- zero is computed on the final registered result.
- Flags are cleared on every accept and change only when DONE is entered.

Test Plan:
1. WIDTH=4: op=000, a=7, b=9 -> after 1 cycle out_valid=1, result=0x00, carry=1, zero=1.
2. WIDTH=4: op=011, a=15, b=15 -> in_ready=0 for 5 cycles, out_valid on cycle 5 after accept, result=0xE1, carry=0.
3. WIDTH=4: op=100, a=13, b=4 -> result=0x13 (remainder 1, quotient 3), div_zero=0. Then op=101, a=4, b=13 -> same result 0x13.
4. WIDTH=4: op=100, a=5, b=0 -> latency 1, result=0x5F, div_zero=1, zero=0.
5. Backpressure and subtract: op=001, a=3, b=5, out_ready held 0 for 10 cycles -> result=0x0E, carry=1, stable throughout, in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1.
6. Reset and width sweep:
   - Start op=011 a=9 b=9, assert rst_n=0 at BUSY cycle 2 -> next cycle out_valid=0, result=0, in_ready=1.
   - Repeat scenarios 1 to 4 at WIDTH=8: 255*255 -> 0xFE01; 200/7 -> {0x04, 0x1C}.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked unsigned ALU: single-cycle add/sub/logic ops, iterative
// shift-add multiply and restoring divide, with carry/zero/div-by-zero flags.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 zero,
  output logic                 div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_SUB_BA = 3'b010;
  localparam logic [2:0] OP_MUL    = 3'b011;
  localparam logic [2:0] OP_DIV_AB = 3'b100;
  localparam logic [2:0] OP_DIV_BA = 3'b101;
  localparam logic [2:0] OP_AND    = 3'b110;
  localparam logic [2:0] OP_OR     = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     opnd_q;
  logic                 is_mul_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 carry_q;
  logic                 zero_q;
  logic                 div_zero_q;

  // Accept-side decode and the single-cycle results
  logic [WIDTH:0]       sum_d;
  logic [WIDTH:0]       diff_ab_d;
  logic [WIDTH:0]       diff_ba_d;
  logic [WIDTH-1:0]     dividend_d;
  logic [WIDTH-1:0]     divisor_d;
  logic                 is_div_d;
  logic                 is_iter_d;
  logic [2*WIDTH-1:0]   quick_result_d;
  logic                 quick_carry_d;
  logic                 quick_dz_d;

  always_comb begin
    sum_d          = {1'b0, a} + {1'b0, b};
    diff_ab_d      = {1'b0, a} - {1'b0, b};
    diff_ba_d      = {1'b0, b} - {1'b0, a};
    dividend_d     = (op == OP_DIV_BA) ? b : a;
    divisor_d      = (op == OP_DIV_BA) ? a : b;
    is_div_d       = (op == OP_DIV_AB) || (op == OP_DIV_BA);
    is_iter_d      = (op == OP_MUL) || (is_div_d && (divisor_d != '0));
    quick_result_d = '0;
    quick_carry_d  = 1'b0;
    quick_dz_d     = 1'b0;
    case (op)
      OP_ADD: begin
        quick_result_d[WIDTH-1:0] = sum_d[WIDTH-1:0];
        quick_carry_d             = sum_d[WIDTH];
      end
      OP_SUB_AB: begin
        quick_result_d[WIDTH-1:0] = diff_ab_d[WIDTH-1:0];
        quick_carry_d             = diff_ab_d[WIDTH];
      end
      OP_SUB_BA: begin
        quick_result_d[WIDTH-1:0] = diff_ba_d[WIDTH-1:0];
        quick_carry_d             = diff_ba_d[WIDTH];
      end
      OP_AND: quick_result_d[WIDTH-1:0] = a & b;
      OP_OR:  quick_result_d[WIDTH-1:0] = a | b;
      // Only reached for a zero divisor: quotient saturates, remainder keeps the dividend
      OP_DIV_AB, OP_DIV_BA: begin
        quick_result_d = {dividend_d, {WIDTH{1'b1}}};
        quick_dz_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // One iteration step; hi/lo hold {partial product} or {remainder, quotient}
  logic [WIDTH:0]       mul_sum_d;
  logic [WIDTH:0]       div_shift_d;
  logic [WIDTH-1:0]     div_trial_d;
  logic                 div_ge_d;
  logic [WIDTH-1:0]     step_hi_d;
  logic [WIDTH-1:0]     step_lo_d;

  always_comb begin
    mul_sum_d   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift_d = {hi_q, lo_q[WIDTH-1]};
    div_ge_d    = (div_shift_d >= {1'b0, opnd_q});
    div_trial_d = div_shift_d[WIDTH-1:0] - opnd_q;
    if (is_mul_q) begin
      step_hi_d = mul_sum_d[WIDTH:1];
      step_lo_d = {mul_sum_d[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi_d = div_ge_d ? div_trial_d : div_shift_d[WIDTH-1:0];
      step_lo_d = {lo_q[WIDTH-2:0], div_ge_d};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      is_mul_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (is_iter_d) begin
              carry_q    <= 1'b0;
              zero_q     <= 1'b0;
              div_zero_q <= 1'b0;
              is_mul_q   <= (op == OP_MUL);
              hi_q       <= '0;
              lo_q       <= (op == OP_MUL) ? b : dividend_d;
              opnd_q     <= (op == OP_MUL) ? a : divisor_d;
              cnt_q      <= CW'(WIDTH - 1);
              state_q    <= BUSY;
            end else begin
              result_q    <= quick_result_d;
              carry_q     <= quick_carry_d;
              zero_q      <= (quick_result_d == '0);
              div_zero_q  <= quick_dz_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        BUSY: begin
          hi_q  <= step_hi_d;
          lo_q  <= step_lo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q    <= {step_hi_d, step_lo_d};
            zero_q      <= ({step_hi_d, step_lo_d} == '0);
            carry_q     <= 1'b0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4 and WIDTH=8 with hand-computed results.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic        carry4, zero4, div_zero4;
  logic [2:0]  op4;
  logic [3:0]  a4, b4;
  logic [7:0]  result4;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic        carry8, zero8, div_zero8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] result8;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op4), .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .result(result4), .carry(carry4), .zero(zero4), .div_zero(div_zero4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .carry(carry8), .zero(zero8), .div_zero(div_zero8)
  );

  // Present one operation for a single edge, then scramble the inputs
  task automatic issue4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    in_valid4 = 1'b1; op4 = o; a4 = x; b4 = y;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    op4 = 3'($urandom_range(7)); a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    op8 = 3'($urandom_range(7)); a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  // Count cycles from accept to out_valid, bounded; note any in_ready while waiting
  task automatic wait4(output int n, output bit rdy);
    n = 1; rdy = 1'b0;
    while (out_valid4 !== 1'b1 && n < 40) begin
      if (in_ready4 !== 1'b0) rdy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait8(output int n, output bit rdy);
    n = 1; rdy = 1'b0;
    while (out_valid8 !== 1'b1 && n < 40) begin
      if (in_ready8 !== 1'b0) rdy = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    tests_run++; if (out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid4); end
    tests_run++; if (in_ready4 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready4); end
    tests_run++; if (result4 !== 8'h00) begin tests_failed++; $display("FAIL reset_result: got %h expected 00", result4); end
    tests_run++; if ({carry4, zero4, div_zero4} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {carry4, zero4, div_zero4}); end
    tests_run++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin tests_failed++; $display("FAIL reset_w8: got valid=%b ready=%b expected valid=0 ready=1", out_valid8, in_ready8); end
    $display("[TB] reset: out_valid=%b in_ready=%b result=%h", out_valid4, in_ready4, result4);
  endtask

  task automatic test_add();
    int n; bit rdy;
    issue4(3'b000, 4'd7, 4'd9);
    wait4(n, rdy);
    $display("[TB] add 7+9: lat=%0d result=%h c=%b z=%b dz=%b", n, result4, carry4, zero4, div_zero4);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL add_latency: got %0d expected 1", n); end
    tests_run++; if (result4 !== 8'h00) begin tests_failed++; $display("FAIL add_result: got %h expected 00", result4); end
    tests_run++; if ({carry4, zero4, div_zero4} !== 3'b110) begin tests_failed++; $display("FAIL add_flags: got %b expected 110", {carry4, zero4, div_zero4}); end
    tests_run++; if (in_ready4 !== 1'b0) begin tests_failed++; $display("FAIL add_ready_done: got %b expected 0", in_ready4); end
    @(posedge clk); #1;
    tests_run++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin tests_failed++; $display("FAIL add_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid4, in_ready4); end
  endtask

  task automatic test_mul();
    int n; bit rdy;
    issue4(3'b011, 4'd15, 4'd15);
    wait4(n, rdy);
    $display("[TB] mul 15*15: lat=%0d result=%h c=%b z=%b", n, result4, carry4, zero4);
    tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL mul_latency: got %0d expected 5", n); end
    tests_run++; if (rdy !== 1'b0) begin tests_failed++; $display("FAIL mul_busy_ready: got ready seen=%b expected 0", rdy); end
    tests_run++; if (result4 !== 8'hE1) begin tests_failed++; $display("FAIL mul_result: got %h expected e1", result4); end
    tests_run++; if ({carry4, zero4} !== 2'b00) begin tests_failed++; $display("FAIL mul_flags: got %b expected 00", {carry4, zero4}); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int n; bit rdy;
    issue4(3'b100, 4'd13, 4'd4);
    wait4(n, rdy);
    $display("[TB] div 13/4: lat=%0d result=%h dz=%b", n, result4, div_zero4);
    tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL div_ab_latency: got %0d expected 5", n); end
    tests_run++; if (result4 !== 8'h13) begin tests_failed++; $display("FAIL div_ab_result: got %h expected 13", result4); end
    tests_run++; if ({carry4, div_zero4} !== 2'b00) begin tests_failed++; $display("FAIL div_ab_flags: got %b expected 00", {carry4, div_zero4}); end
    @(posedge clk); #1;
    issue4(3'b101, 4'd4, 4'd13);
    wait4(n, rdy);
    $display("[TB] div 13/4 (b/a): lat=%0d result=%h dz=%b", n, result4, div_zero4);
    tests_run++; if (result4 !== 8'h13) begin tests_failed++; $display("FAIL div_ba_result: got %h expected 13", result4); end
    tests_run++; if (div_zero4 !== 1'b0) begin tests_failed++; $display("FAIL div_ba_dz: got %b expected 0", div_zero4); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int n; bit rdy;
    issue4(3'b100, 4'd5, 4'd0);
    wait4(n, rdy);
    $display("[TB] div 5/0: lat=%0d result=%h z=%b dz=%b", n, result4, zero4, div_zero4);
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL divz_latency: got %0d expected 1", n); end
    tests_run++; if (result4 !== 8'h5F) begin tests_failed++; $display("FAIL divz_result: got %h expected 5f", result4); end
    tests_run++; if ({carry4, zero4, div_zero4} !== 3'b001) begin tests_failed++; $display("FAIL divz_flags: got %b expected 001", {carry4, zero4, div_zero4}); end
    @(posedge clk); #1;
    issue4(3'b110, 4'b1100, 4'b1010);
    wait4(n, rdy);
    $display("[TB] and c&a: lat=%0d result=%h dz=%b", n, result4, div_zero4);
    tests_run++; if (result4 !== 8'h08 || div_zero4 !== 1'b0) begin tests_failed++; $display("FAIL and_after_divz: got %h dz=%b expected 08 dz=0", result4, div_zero4); end
    @(posedge clk); #1;
    issue4(3'b111, 4'b1100, 4'b0010);
    wait4(n, rdy);
    $display("[TB] or c|2: lat=%0d result=%h", n, result4);
    tests_run++; if (result4 !== 8'h0E) begin tests_failed++; $display("FAIL or_result: got %h expected 0e", result4); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n; bit rdy; int bad;
    out_ready4 = 1'b0;
    issue4(3'b001, 4'd3, 4'd5);
    wait4(n, rdy);
    $display("[TB] sub 3-5 held: lat=%0d result=%h c=%b", n, result4, carry4);
    bad = 0;
    // A stray request during DONE must not disturb the held result
    in_valid4 = 1'b1; op4 = 3'b000; a4 = 4'd1; b4 = 4'd1;
    for (int i = 0; i < 10; i++) begin
      if (result4 !== 8'h0E || carry4 !== 1'b1 || out_valid4 !== 1'b1 || in_ready4 !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    in_valid4 = 1'b0;
    tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL bp_latency: got %0d expected 1", n); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad); end
    tests_run++; if (result4 !== 8'h0E || carry4 !== 1'b1) begin tests_failed++; $display("FAIL bp_final: got %h c=%b expected 0e c=1", result4, carry4); end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin tests_failed++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid4, in_ready4); end
  endtask

  task automatic test_reset_busy();
    int n; bit rdy; int stray;
    issue4(3'b011, 4'd9, 4'd9);
    @(posedge clk); #1;
    tests_run++; if (in_ready4 !== 1'b0) begin tests_failed++; $display("FAIL rb_busy: got ready=%b expected 0", in_ready4); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("[TB] reset in busy: out_valid=%b result=%h in_ready=%b", out_valid4, result4, in_ready4);
    tests_run++; if (out_valid4 !== 1'b0 || result4 !== 8'h00 || in_ready4 !== 1'b1) begin tests_failed++; $display("FAIL rb_state: got valid=%b result=%h ready=%b expected 0 00 1", out_valid4, result4, in_ready4); end
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid4 !== 1'b0) stray++;
      @(posedge clk); #1;
    end
    tests_run++; if (stray !== 0) begin tests_failed++; $display("FAIL rb_discard: got %0d valid cycles expected 0", stray); end
    issue4(3'b010, 4'd9, 4'd4);
    wait4(n, rdy);
    $display("[TB] sub 4-9 after reset: lat=%0d result=%h c=%b", n, result4, carry4);
    tests_run++; if (result4 !== 8'h0B || carry4 !== 1'b1) begin tests_failed++; $display("FAIL rb_next: got %h c=%b expected 0b c=1", result4, carry4); end
    @(posedge clk); #1;
  endtask

  task automatic test_width8();
    logic [2:0]  t_op  [6] = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b100, 3'b000};
    logic [7:0]  t_a   [6] = '{8'd200, 8'd255, 8'd200, 8'd7, 8'd5, 8'd7};
    logic [7:0]  t_b   [6] = '{8'd100, 8'd255, 8'd7, 8'd200, 8'd0, 8'd9};
    logic [15:0] t_res [6] = '{16'h002C, 16'hFE01, 16'h041C, 16'h041C, 16'h05FF, 16'h0010};
    logic [2:0]  t_flg [6] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    int          t_lat [6] = '{1, 9, 9, 9, 1, 1};
    int n; bit rdy;
    for (int i = 0; i < 6; i++) begin
      issue8(t_op[i], t_a[i], t_b[i]);
      wait8(n, rdy);
      $display("[TB] w8 op=%0d a=%0d b=%0d: lat=%0d result=%h c=%b z=%b dz=%b", t_op[i], t_a[i], t_b[i], n, result8, carry8, zero8, div_zero8);
      tests_run++; if (n !== t_lat[i]) begin tests_failed++; $display("FAIL w8_latency[%0d]: got %0d expected %0d", i, n, t_lat[i]); end
      tests_run++; if (result8 !== t_res[i]) begin tests_failed++; $display("FAIL w8_result[%0d]: got %h expected %h", i, result8, t_res[i]); end
      tests_run++; if ({carry8, zero8, div_zero8} !== t_flg[i]) begin tests_failed++; $display("FAIL w8_flags[%0d]: got %b expected %b", i, {carry8, zero8, div_zero8}, t_flg[i]); end
      tests_run++; if (t_lat[i] > 1 && rdy !== 1'b0) begin tests_failed++; $display("FAIL w8_busy_ready[%0d]: got ready seen=%b expected 0", i, rdy); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; op4 = '0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_busy();
    test_width8();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
